// File: rtl/camera_pkg.sv
// Shared constants, FSM state encoding and frame layout helper for the
// emulated Wii IR camera I2C target.
package camera_pkg;

   localparam logic [6:0]  CAM_I2C_ADDR = 7'h58;
   localparam logic [7:0]  REG_CONF_A   = 8'h30;
   localparam logic [7:0]  REG_CONF_B   = 8'h33;
   localparam logic [7:0]  REG_DATA     = 8'h36;
   localparam int unsigned FRAME_BYTES  = 16;
   localparam logic [7:0]  REG_DATA_LAST = REG_DATA + 8'(FRAME_BYTES - 1);

   typedef enum logic [2:0] {
      StIdle,
      StAddr,
      StAddrAck,
      StWrByte,
      StWrAck,
      StRdByte,
      StRdAck,
      StIgnore
   } i2c_state_e;

   // One byte of the 16-byte position report; a missing blob reads as all-ones.
   function automatic logic [7:0] frame_byte(input logic [3:0] idx,
                                             input logic [9:0] x,
                                             input logic [9:0] y,
                                             input logic [3:0] size,
                                             input logic       valid);
      logic [7:0] b;
      case (idx)
         4'd0:    b = 8'h00;
         4'd1:    b = valid ? x[7:0] : 8'hFF;
         4'd2:    b = valid ? y[7:0] : 8'hFF;
         4'd3:    b = valid ? {y[9:8], x[9:8], size} : 8'hFF;
         default: b = 8'hFF;
      endcase
      return b;
   endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchroniser for one raw I2C line plus registered-history edge strobes.
module i2c_line_sync (
   input  logic clk,
   input  logic line_in,
   output logic level,
   output logic rise,
   output logic fall
);

   logic meta_q, sync_q, prev_q;

   // Left unreset on purpose: a reset must never manufacture a bus edge.
   always_ff @(posedge clk) begin
      meta_q <= line_in;
      sync_q <= meta_q;
      prev_q <= sync_q;
   end

   // Edge strobes compare the synchronised level against its previous sample.
   always_comb begin
      level = sync_q;
      rise  = sync_q & ~prev_q;
      fall  = ~sync_q & prev_q;
   end

endmodule

// File: rtl/ir_camera_target.sv
// I2C target emulating the Wii IR camera: stores config registers 0x30/0x33,
// keeps a register pointer and serves a 16-byte blob report snapshotted at
// read-address acknowledge.
module ir_camera_target
   import camera_pkg::*;
#(
   parameter logic [6:0] I2C_ADDR = CAM_I2C_ADDR
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       i2c_scl,
   input  logic       i2c_sda_in,
   output logic       i2c_sda,
   input  logic [9:0] blob_x,
   input  logic [9:0] blob_y,
   input  logic [3:0] blob_size,
   input  logic       blob_valid,
   output logic [7:0] conf_30,
   output logic [7:0] conf_33,
   output logic       busy
);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;

   i2c_line_sync u_scl_sync (
      .clk     (clk),
      .line_in (i2c_scl),
      .level   (scl_lvl),
      .rise    (scl_rise),
      .fall    (scl_fall)
   );

   i2c_line_sync u_sda_sync (
      .clk     (clk),
      .line_in (i2c_sda_in),
      .level   (sda_lvl),
      .rise    (sda_rise),
      .fall    (sda_fall)
   );

   logic start_cond, stop_cond;
   assign start_cond = sda_fall & scl_lvl;
   assign stop_cond  = sda_rise & scl_lvl;

   i2c_state_e state_q, state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] ptr_q, ptr_d;
   logic       first_q, first_d;
   logic       sda_q, sda_d;
   logic [7:0] tx_q, tx_d;
   logic [7:0] conf30_q, conf30_d;
   logic [7:0] conf33_q, conf33_d;
   logic [9:0] snap_x_q, snap_x_d;
   logic [9:0] snap_y_q, snap_y_d;
   logic [3:0] snap_size_q, snap_size_d;
   logic       snap_valid_q, snap_valid_d;

   logic [7:0] wr_data;
   logic [3:0] frame_idx;
   logic       ptr_in_frame;
   logic [7:0] rd_byte;

   // Byte assembled on the eighth rising edge, and the report byte at ptr.
   always_comb begin
      wr_data      = {shift_q[6:0], sda_lvl};
      frame_idx    = 4'(ptr_q - REG_DATA);
      ptr_in_frame = (ptr_q >= REG_DATA) && (ptr_q <= REG_DATA_LAST);
      rd_byte      = ptr_in_frame ?
                     frame_byte(frame_idx, snap_x_q, snap_y_q, snap_size_q, snap_valid_q) :
                     8'h00;
   end

   // Next-state logic: bus conditions first, then SCL-edge driven protocol steps.
   always_comb begin
      state_d      = state_q;
      bit_cnt_d    = bit_cnt_q;
      shift_d      = shift_q;
      ptr_d        = ptr_q;
      first_d      = first_q;
      sda_d        = sda_q;
      tx_d         = tx_q;
      conf30_d     = conf30_q;
      conf33_d     = conf33_q;
      snap_x_d     = snap_x_q;
      snap_y_d     = snap_y_q;
      snap_size_d  = snap_size_q;
      snap_valid_d = snap_valid_q;

      if (start_cond) begin
         state_d   = StAddr;
         bit_cnt_d = 4'd0;
         sda_d     = 1'b1;
      end else if (stop_cond) begin
         state_d = StIdle;
         sda_d   = 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
            end

            StAddr: begin
               if (scl_rise && bit_cnt_q < 4'd8) begin
                  shift_d   = wr_data;
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  if (shift_q[7:1] == I2C_ADDR) begin
                     state_d = StAddrAck;
                     sda_d   = 1'b0;
                     first_d = 1'b1;
                     if (shift_q[0]) begin
                        snap_x_d     = blob_x;
                        snap_y_d     = blob_y;
                        snap_size_d  = blob_size;
                        snap_valid_d = blob_valid;
                     end
                  end else begin
                     state_d = StIgnore;
                  end
               end
            end

            StAddrAck: begin
               if (scl_fall) begin
                  bit_cnt_d = 4'd0;
                  if (shift_q[0]) begin
                     state_d = StRdByte;
                     tx_d    = rd_byte;
                     sda_d   = rd_byte[7];
                  end else begin
                     state_d = StWrByte;
                     sda_d   = 1'b1;
                  end
               end
            end

            StWrByte: begin
               if (scl_rise && bit_cnt_q < 4'd8) begin
                  shift_d   = wr_data;
                  bit_cnt_d = bit_cnt_q + 4'd1;
                  if (bit_cnt_q == 4'd7) begin
                     if (first_q) begin
                        ptr_d   = wr_data;
                        first_d = 1'b0;
                     end else begin
                        if (ptr_q == REG_CONF_A) conf30_d = wr_data;
                        if (ptr_q == REG_CONF_B) conf33_d = wr_data;
                        ptr_d = ptr_q + 8'd1;
                     end
                  end
               end else if (scl_fall && bit_cnt_q == 4'd8) begin
                  state_d = StWrAck;
                  sda_d   = 1'b0;
               end
            end

            StWrAck: begin
               if (scl_fall) begin
                  state_d   = StWrByte;
                  sda_d     = 1'b1;
                  bit_cnt_d = 4'd0;
               end
            end

            StRdByte: begin
               if (scl_rise && bit_cnt_q < 4'd8) begin
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end else if (scl_fall) begin
                  if (bit_cnt_q == 4'd8) begin
                     state_d   = StRdAck;
                     sda_d     = 1'b1;
                     ptr_d     = ptr_q + 8'd1;
                     bit_cnt_d = 4'd0;
                  end else begin
                     sda_d = tx_q[3'd7 - bit_cnt_q[2:0]];
                  end
               end
            end

            StRdAck: begin
               // bit_cnt marks that the master's ACK has been seen.
               if (scl_rise && bit_cnt_q == 4'd0) begin
                  if (sda_lvl) state_d = StIgnore;
                  else bit_cnt_d = 4'd1;
               end else if (scl_fall && bit_cnt_q == 4'd1) begin
                  state_d   = StRdByte;
                  bit_cnt_d = 4'd0;
                  tx_d      = rd_byte;
                  sda_d     = rd_byte[7];
               end
            end

            StIgnore: begin
            end

            default: state_d = StIdle;
         endcase
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= StIdle;
         bit_cnt_q    <= 4'd0;
         shift_q      <= 8'h00;
         ptr_q        <= 8'h00;
         first_q      <= 1'b0;
         sda_q        <= 1'b1;
         tx_q         <= 8'h00;
         conf30_q     <= 8'h00;
         conf33_q     <= 8'h00;
         snap_x_q     <= 10'd0;
         snap_y_q     <= 10'd0;
         snap_size_q  <= 4'd0;
         snap_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         bit_cnt_q    <= bit_cnt_d;
         shift_q      <= shift_d;
         ptr_q        <= ptr_d;
         first_q      <= first_d;
         sda_q        <= sda_d;
         tx_q         <= tx_d;
         conf30_q     <= conf30_d;
         conf33_q     <= conf33_d;
         snap_x_q     <= snap_x_d;
         snap_y_q     <= snap_y_d;
         snap_size_q  <= snap_size_d;
         snap_valid_q <= snap_valid_d;
      end
   end

   // Outputs are straight register copies so the pin never glitches.
   always_comb begin
      i2c_sda = sda_q;
      conf_30 = conf30_q;
      conf_33 = conf33_q;
      busy    = (state_q != StIdle);
   end

endmodule

// File: doc/ir_camera_target.md
# ir_camera_target

I2C target (responder) that emulates the Wii IR camera at address 0x58 on the same two-wire bus our camera reader masters. It accepts configuration register writes and a register-pointer write, then returns a 16-byte position report built from live blob inputs. It is synthesisable: it serves as the on-board stand-in camera for bring-up and as the bus-level model in the camera-reader bench.

## Interface
- I2C_ADDR, 7'h58, 7-bit target address.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- i2c_scl  in  1  bus clock from the master (raw, unsynchronised).
- i2c_sda_in  in  1  bus data as seen on the pin (raw).
- i2c_sda  out  1  open-drain control: 0 = pull low, 1 = release.
- blob_x  in  10  blob X coordinate.
- blob_y  in  10  blob Y coordinate.
- blob_size  in  4  blob size.
- blob_valid  in  1  blob present.
- conf_30  out  8  last value written to register 0x30.
- conf_33  out  8  last value written to register 0x33.
- busy  out  1  high from START to STOP/abort.

## Operation
- SCL and SDA each pass through a 2-flop synchroniser; edges are detected on the synchronised copies.
- START/repeated START = SDA falling while SCL high. STOP = SDA rising while SCL high. Both are honoured in every state.
  - START -> ADDR, bit counter cleared.
  - STOP -> IDLE, SDA released.
- Bits are sampled on SCL rising. i2c_sda changes only on SCL falling.
- States:
  - IDLE: wait for START.
  - ADDR: shift 8 bits, address MSB first, then R/W.
  - ADDR_ACK: on address match, drive ACK. Otherwise go to IGNORE (SDA released).
  - WR_BYTE: receive 8 bits.
  - WR_ACK: always ACK.
  - RD_BYTE: drive 8 bits, MSB first.
  - RD_ACK: release SDA and sample the master's ACK on SCL rising. ACK -> RD_BYTE. NACK -> IGNORE.
  - IGNORE: wait for START or STOP.
- Write transaction:
  - First data byte loads the 8-bit register pointer `ptr`.
  - Each later byte writes register[ptr], then ptr increments.
  - Only 0x30 and 0x33 are stored; writes to other registers are ACKed and discarded.
  - ptr wraps 0xFF -> 0x00.
- Read transaction: each byte returns frame[ptr - 0x36] when ptr is in 0x36..0x45, else 0x00. ptr increments after each byte.
- Frame contents:
  - byte0 = 0x00.
  - byte1 = x[7:0].
  - byte2 = y[7:0].
  - byte3 = {y[9:8], x[9:8], size[3:0]}.
  - bytes4..15 = 0xFF.
  - When blob_valid = 0, bytes 1..3 are also 0xFF.
- Snapshot: blob inputs are captured once, when a read-address match is ACKed. The frame is stable for the whole transaction.
- busy = state != IDLE.

## Timing
- Reset values: i2c_sda = 1, conf_30 = 0, conf_33 = 0, busy = 0, ptr = 0, state IDLE.
- Reset mid-transfer: SDA released on the cycle after reset is sampled. The block then waits for a fresh START.
- Input-to-decision latency is 3 clk: 2 synchroniser stages plus edge register.
- Required bus rate: SCL high and low phases each ≥ 6 clk.
- SDA drive:
  - Applied 1 clk after the detected SCL falling edge.
  - ACK is held low from the falling edge after bit 8 to the falling edge after bit 9.
  - Read data bit n is held from one falling edge to the next.
- conf_30/conf_33 update 1 clk after the SCL rising edge that samples bit 0 of the data byte.
- START/STOP detection takes priority over SCL edge processing in the same cycle.

## Structure
- Shared package `camera_pkg`: CAM_I2C_ADDR (7'h58), REG_CONF_A (8'h30), REG_CONF_B (8'h33), REG_DATA (8'h36), FRAME_BYTES (16), and state encodings.
- One sub-module, `i2c_line_sync`: 2-flop synchroniser plus rise/fall edge strobes for one line, instantiated for SCL and for SDA.

## Test plan
- Write 0x58/W with (0x30,0x01), (0x30,0x08), (0x33,0x33) -> every byte ACKed; conf_30 = 0x08, conf_33 = 0x33.
- Write ptr 0x36, then read 16 bytes with x = 0x2A5, y = 0x1C3, size = 5, valid = 1 -> 00 A5 C3 65 FF×12; master NACKs the last byte; busy drops after STOP.
- Address 0x21 -> address NACKed; SDA never driven; conf registers unchanged.
- blob inputs change mid-read -> returned frame matches the values at address ACK; blob_valid = 0 -> bytes 1..3 = FF.
- Master NACKs after byte 4, then repeated START + 0x58/R -> new frame begins at ptr 0x3A (4 reads after 0x36, no write in between), byte value 0xFF.
- reset asserted during byte 2 of a read -> i2c_sda = 1 next cycle; subsequent full transaction succeeds.
